// File: rtl/serial_word_shifter_pkg.sv
// rtl/serial_word_shifter_pkg.sv - shared state encodings and constants for the serial shifter and detector
package serial_word_shifter_pkg;

    // Serialiser control states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sws_state_e;

    localparam int SWS_DEFAULT_WIDTH = 8;

    // Downstream pattern detector states and the pattern it looks for
    typedef enum logic [1:0] {
        DET_S0  = 2'd0,
        DET_S1  = 2'd1,
        DET_S10 = 2'd2
    } det_state_e;

    localparam logic [2:0] DET_PATTERN = 3'b101;

endpackage

// File: rtl/serial_word_shifter_shift_bit_counter.sv
// rtl/serial_word_shifter_shift_bit_counter.sv - loadable shift register with bit counter and last-bit flag
module shift_bit_counter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             shift_en,
    output logic             ser_bit,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    // Load restarts the count; a shift moves the next bit to the output end
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = load_word;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign ser_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign last_bit = (bit_cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_word_shifter.sv
// rtl/serial_word_shifter.sv - parallel-to-serial word shifter with one-word holding register
module serial_word_shifter
    import serial_word_shifter_pkg::*;
#(
    parameter int WIDTH     = SWS_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             bit_valid,
    output logic             word_last,
    output logic             busy
);

    sws_state_e       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             xfer;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic             shift_en;
    logic             ser_bit;
    logic             last_bit;

    assign xfer = din_valid && !hold_full_q;

    // Control: choose between loading a new word, shifting, parking a word in hold, or idling
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        load_word   = din;
        shift_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (hold_full_q) begin
                        load        = 1'b1;
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_en = 1'b1;
                    if (xfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    shift_bit_counter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_bit_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (load_word),
        .shift_en  (shift_en),
        .ser_bit   (ser_bit),
        .last_bit  (last_bit)
    );

    // Outputs decode registered state only; IDLE forces the serial line low
    assign din_ready = !hold_full_q;
    assign bit_valid = (state_q == SHIFT);
    assign ser_out   = bit_valid && ser_bit;
    assign word_last = bit_valid && last_bit;
    assign busy      = bit_valid || hold_full_q;

endmodule

// File: tb/tb_serial_word_shifter.sv
// tb/tb_serial_word_shifter.sv - self-checking bench for serial_word_shifter, both bit orders
module tb_serial_word_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic m_ready, m_ser, m_valid, m_last, m_busy;
    logic l_ready, l_ser, l_valid, l_last, l_busy;

    always #5 clk = ~clk;

    serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .ser_out(m_ser), .bit_valid(m_valid),
        .word_last(m_last), .busy(m_busy)
    );

    serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .ser_out(l_ser), .bit_valid(l_valid),
        .word_last(l_last), .busy(l_busy)
    );

    // Reference: a queue of bits still to appear on the line, front = bit currently shown
    typedef struct packed {
        logic b;
        logic last;
    } mbit_t;

    mbit_t qm[$];
    mbit_t ql[$];
    logic  seen_m[$];
    logic  seen_l[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic v, em, el, lm, ll, rdy;
        v   = (qm.size() > 0);
        em  = 1'b0; el = 1'b0; lm = 1'b0; ll = 1'b0;
        if (v) begin
            em = qm[0].b;  lm = qm[0].last;
            el = ql[0].b;  ll = ql[0].last;
        end
        // A second word is waiting whenever more than one word's bits remain
        rdy = (qm.size() <= W);
        chk("msb_ser_out",   32'(m_ser),   32'(em));
        chk("lsb_ser_out",   32'(l_ser),   32'(el));
        chk("msb_bit_valid", 32'(m_valid), 32'(v));
        chk("lsb_bit_valid", 32'(l_valid), 32'(v));
        chk("msb_word_last", 32'(m_last),  32'(lm));
        chk("lsb_word_last", 32'(l_last),  32'(ll));
        chk("msb_busy",      32'(m_busy),  32'(v));
        chk("lsb_busy",      32'(l_busy),  32'(v));
        chk("msb_din_ready", 32'(m_ready), 32'(rdy));
        chk("lsb_din_ready", 32'(l_ready), 32'(rdy));
    endtask

    // One clock: check at negedge, drive inputs, then advance the model on the posedge
    task automatic step(input logic v, input logic [W-1:0] d);
        logic acc;
        @(negedge clk);
        check_outputs();
        if (m_valid) seen_m.push_back(m_ser);
        if (l_valid) seen_l.push_back(l_ser);
        din       = d;
        din_valid = v;
        acc       = v && (qm.size() <= W);
        @(posedge clk);
        if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                qm.push_back('{b: d[W-1-i], last: (i == W-1)});
                ql.push_back('{b: d[i],     last: (i == W-1)});
            end
        end
    endtask

    function automatic logic [31:0] pack_seen_m(input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n && i < seen_m.size(); i++) r = {r[30:0], seen_m[i]};
        return r;
    endfunction

    function automatic logic [31:0] pack_seen_l(input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n && i < seen_l.size(); i++) r = {r[30:0], seen_l[i]};
        return r;
    endfunction

    function automatic int count_101();
        int c = 0;
        for (int i = 0; i + 2 < seen_m.size(); i++)
            if (seen_m[i] && !seen_m[i+1] && seen_m[i+2]) c++;
        return c;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic clear_seen();
        seen_m.delete();
        seen_l.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single word A0, MSB first: 1,0,1,0,0,0,0,0 then idle
        clear_seen();
        step(1'b1, 8'hA0);
        idle(9);
        chk("a0_bit_count", 32'(seen_m.size()), 32'd8);
        chk("a0_bits",      pack_seen_m(8),     32'h0000_00A0);

        // LSB-first 01: first bit on the line is 1, rest 0
        clear_seen();
        step(1'b1, 8'h01);
        idle(9);
        chk("lsb01_bit_count", 32'(seen_l.size()), 32'd8);
        chk("lsb01_bits",      pack_seen_l(8),     32'h0000_0080);

        // Back-to-back A5, 5A: 16 contiguous bits
        clear_seen();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h5A);
        idle(17);
        chk("b2b_bit_count", 32'(seen_m.size()), 32'd16);
        chk("b2b_bits",      pack_seen_m(16),    32'h0000_A55A);

        // Detector feed A5, A5: 101 occurs 4 times across the 16-bit stream
        clear_seen();
        step(1'b1, 8'hA5);
        step(1'b1, 8'hA5);
        idle(17);
        chk("det_101_count", 32'(count_101()), 32'd4);

        // Bypass: second word offered only on the last-bit cycle
        clear_seen();
        step(1'b1, 8'hA5);
        idle(7);
        step(1'b1, 8'h3C);
        idle(10);
        chk("bypass_bit_count", 32'(seen_m.size()), 32'd16);
        chk("bypass_bits",      pack_seen_m(16),    32'h0000_A53C);

        // Reset mid-word with a held word
        clear_seen();
        step(1'b1, 8'hFF);
        step(1'b1, 8'h96);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_msb_ser_out",   32'(m_ser),   32'd0);
        chk("rst_msb_bit_valid", 32'(m_valid), 32'd0);
        chk("rst_msb_word_last", 32'(m_last),  32'd0);
        chk("rst_msb_busy",      32'(m_busy),  32'd0);
        chk("rst_msb_din_ready", 32'(m_ready), 32'd1);
        chk("rst_lsb_bit_valid", 32'(l_valid), 32'd0);
        chk("rst_lsb_busy",      32'(l_busy),  32'd0);
        chk("rst_lsb_din_ready", 32'(l_ready), 32'd1);
        qm.delete();
        ql.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_seen();
        idle(12);
        chk("post_rst_no_bits", 32'(seen_m.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom));
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
